// File: rtl/int_timer_pkg.sv
// ---------------------------------------------------------------------------
// int_timer_pkg
//   Shared definitions for the programmable countdown timer: FSM state
//   encodings, register word offsets, CTRL field layout and MODE codes.
// ---------------------------------------------------------------------------
package int_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    // Word offsets, selected by bus address bits [3:2]
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;
    localparam logic [1:0] AddrRsvd   = 2'd3;

    localparam logic [1:0] ModeOneShot = 2'd0;
    localparam logic [1:0] ModeReload  = 2'd1;

    // Field order matches CTRL[3:0]: {IM, MODE[1:0], EN}
    localparam int unsigned CtrlW = 4;
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // MODE codes 2 and 3 fall back to one-shot behaviour
    function automatic logic is_reload(input ctrl_t c);
        return c.mode == ModeReload;
    endfunction

endpackage

// File: rtl/int_timer_if.sv
// ---------------------------------------------------------------------------
// int_timer_if
//   Bridge bus slice seen by the timer.
//     Addr  word select (address bits [3:2])
//     WE    write enable, sampled on the rising clock edge
//     DIN   write data
//     DOUT  combinational read data of the word selected by Addr
// ---------------------------------------------------------------------------
interface int_timer_if;

    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;

    modport master (
        output Addr,
        output WE,
        output DIN,
        input  DOUT
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DIN,
        output DOUT
    );

endinterface

// File: rtl/int_timer.sv
// ---------------------------------------------------------------------------
// int_timer
//   Memory-mapped countdown timer. Counting down to zero sets a pending
//   interrupt; one-shot mode holds it until a CTRL write, auto-reload mode
//   pulses it for one cycle and restarts from PRESET.
// Ports
//   Clock  system clock, all state on posedge
//   Reset  asynchronous, active-low reset
//   bus    bridge bus slave (Addr, WE, DIN, DOUT)
//   IRQ    interrupt request, irq_pend gated by CTRL.IM
// ---------------------------------------------------------------------------
module int_timer
    import int_timer_pkg::*;
#(
    parameter logic [31:0] RST_PRESET = 32'h0000_0000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    int_timer_if.slave  bus,
    output logic        IRQ
);

    state_e             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_pend_q, irq_pend_d;

    logic               wr_ctrl;
    logic               wr_preset;
    logic               en_eff;

    assign wr_ctrl   = bus.WE && (bus.Addr == AddrCtrl);
    assign wr_preset = bus.WE && (bus.Addr == AddrPreset);

    // A CTRL write clearing EN must stop an active count on the same edge
    assign en_eff = wr_ctrl ? bus.DIN[0] : ctrl_q.en;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;

        if (wr_preset) begin
            preset_d = bus.DIN[CNT_W-1:0];
        end

        case (state_q)
            StIdle: begin
                if (ctrl_q.en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Registered PRESET: a write in this cycle lands next period
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_eff) begin
                    state_d = StIdle;
                end else if (count_q <= CNT_W'(1)) begin
                    // Also catches PRESET=0, so COUNT never wraps
                    count_d    = '0;
                    irq_pend_d = 1'b1;
                    state_d    = StInt;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            StInt: begin
                if (is_reload(ctrl_q)) begin
                    irq_pend_d = 1'b0;
                    state_d    = StLoad;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Software write overrides the FSM's own EN clear and acknowledges
        if (wr_ctrl) begin
            ctrl_d     = ctrl_t'(bus.DIN[CtrlW-1:0]);
            irq_pend_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            preset_q   <= RST_PRESET[CNT_W-1:0];
            count_q    <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        bus.DOUT = '0;
        case (bus.Addr)
            AddrCtrl:   bus.DOUT = 32'(ctrl_q);
            AddrPreset: bus.DOUT = 32'(preset_q);
            AddrCount:  bus.DOUT = 32'(count_q);
            default:    bus.DOUT = '0;
        endcase
    end

    assign IRQ = irq_pend_q & ctrl_q.im;

endmodule

// File: tb/tb_int_timer.sv
// ---------------------------------------------------------------------------
// tb_int_timer
//   Directed bench for int_timer. Inputs change 1 ns after a rising edge;
//   "eN" in tags is the Nth rising edge after the write that set EN.
// ---------------------------------------------------------------------------
module tb_int_timer;

    localparam logic [31:0] RstPreset = 32'h0000_0007;

    logic Clock;
    logic Reset;
    logic IRQ;

    int nvec;
    int nerr;

    int_timer_if bus ();

    int_timer #(
        .RST_PRESET (RstPreset),
        .CNT_W      (32)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus),
        .IRQ   (IRQ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.DIN  = d;
        bus.WE   = 1'b1;
        @(posedge Clock);
        #1;
        bus.WE   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus.Addr = a;
        #1;
        v = bus.DOUT;
        chk(tag, v, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    // Auto-reload, PRESET=3: COUNT and IRQ after edges e1..e11
    int ar_cnt [12] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    int ar_irq [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    initial begin
        nvec    = 0;
        nerr    = 0;
        Reset   = 1'b0;
        bus.WE  = 1'b0;
        bus.Addr = 2'd0;
        bus.DIN = 32'h0;
        #12;
        Reset = 1'b1;
        tick();

        // Reset state
        chk_reg("rst_ctrl", 2'd0, 32'h0);
        chk_reg("rst_preset", 2'd1, RstPreset);
        chk_reg("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // One-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                        // e0
        tick();                                 // e1 LOAD
        tick();                                 // e2
        chk_reg("os_count_e2", 2'd2, 32'd5);
        tick(); tick(); tick(); tick();         // e6
        chk_reg("os_count_e6", 2'd2, 32'd1);
        chk_irq("os_irq_e6", 1'b0);
        tick();                                 // e7
        chk_irq("os_irq_e7", 1'b1);
        tick();                                 // e8 back to IDLE
        chk_reg("os_ctrl_e8", 2'd0, 32'h8);
        chk_reg("os_count_e8", 2'd2, 32'd0);
        tick(); tick();                         // e10
        chk_irq("os_irq_held", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_ack", 1'b0);

        // Auto-reload, PRESET=3, then PRESET rewrite mid-count and stop
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                        // e0
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk_reg($sformatf("ar_count_e%0d", i), 2'd2, 32'(ar_cnt[i]));
            chk_irq($sformatf("ar_irq_e%0d", i), ar_irq[i][0]);
        end
        tick();                                 // e12 COUNT=3
        wr(2'd1, 32'd9);                        // e13
        chk_reg("pre_wr_count", 2'd2, 32'd2);
        tick(); tick();                         // e15
        chk_irq("pre_wr_irq", 1'b1);
        tick(); tick();                         // e17 reloaded with 9
        chk_reg("pre_wr_reload", 2'd2, 32'd9);
        wr(2'd0, 32'h0);                        // e18 EN=0 freezes now
        chk_reg("stop_count", 2'd2, 32'd9);
        tick();
        chk_reg("stop_frozen", 2'd2, 32'd9);
        chk_irq("stop_irq", 1'b0);

        // Masked interrupt, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);                        // e0
        tick(); tick(); tick(); tick();         // e4 pend set
        chk_irq("mask_irq_e4", 1'b0);
        chk_reg("mask_count_e4", 2'd2, 32'd0);
        tick();                                 // e5
        chk_reg("mask_ctrl_e5", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_unmask_cleared", 1'b0);

        // PRESET=0 behaves as 1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);                        // e0
        tick(); tick();                         // e2
        chk_irq("p0_irq_e2", 1'b0);
        tick();                                 // e3
        chk_irq("p0_irq_e3", 1'b1);
        wr(2'd0, 32'h9);                        // e4 INT->IDLE with write
        chk_reg("race_ctrl", 2'd0, 32'h9);
        chk_irq("race_irq", 1'b0);
        tick(); tick(); tick();                 // restarted: INT again
        chk_irq("race_restart_irq", 1'b1);
        wr(2'd0, 32'hFFFF_FF08);
        chk_reg("ctrl_upper_bits", 2'd0, 32'h8);
        chk_irq("ctrl_ack", 1'b0);

        // Read-only COUNT and reserved word
        wr(2'd2, 32'h55);
        chk_reg("count_ro", 2'd2, 32'd0);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("rsvd_read", 2'd3, 32'h0);
        chk_reg("preset_kept", 2'd1, 32'd0);

        // Asynchronous reset while IRQ is high
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);                        // e0
        tick(); tick(); tick(); tick();         // e4
        chk_irq("arst_pre_irq", 1'b1);
        #1;
        Reset = 1'b0;
        #1;
        chk_irq("arst_irq", 1'b0);
        chk_reg("arst_ctrl", 2'd0, 32'h0);
        chk_reg("arst_preset", 2'd1, RstPreset);
        chk_reg("arst_count", 2'd2, 32'h0);
        Reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
